mem_ws_bank: RTL and testbench
==============================

Name: mem_ws_bank

Overview:
- Next-generation single-port valid/ready memory for the memory subsystem.
- Generalised in data width (byte lanes with write strobes) and depth (non-power-of-2 allowed).
- Adds programmable wait states, an out-of-range error response and transaction abort.
- Sits behind a bus master as a slave target and keeps the existing clk/valid/wr_rd/ready request style.

Parameters:
- WIDTH, 32: data width in bits; must be a multiple of 8.
- DEPTH, 200: number of words; need not be a power of 2.
- ADDR_WIDTH, $clog2(DEPTH): address bus width.
- WAIT_STATES, 1: extra cycles between request acceptance and ready; legal range 0..15.
- STRB_WIDTH, WIDTH/8: number of byte lanes; derived, not overridable.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- res_n  in  1  asynchronous active-low reset.
- valid  in  1  request valid; held by the master until ready.
- wr_rd  in  1  1 = write, 0 = read.
- addr  in  ADDR_WIDTH  word address.
- wdata  in  WIDTH  write data.
- wstrb  in  STRB_WIDTH  byte-lane write enables; ignored on reads.
- rdata  out  WIDTH  registered read data.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error flag, coincident with ready.

Behaviour:
- Reset (res_n=0, asynchronous): state=IDLE, ready=0, err=0, rdata=0, wait counter=0. Array contents are not reset.
- IDLE: on valid=1, latch addr, wr_rd, wdata and wstrb.
  - WAIT_STATES=0: go to RESP.
  - Otherwise: load counter=WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. At 0, go to RESP.
- Abort: if valid falls in WAIT, return to IDLE. No write, no ready.
- RESP (one cycle): ready=1, then return to IDLE unconditionally.
- Latency: ready is asserted WAIT_STATES+1 cycles after the cycle in which IDLE sampled valid=1.
- Write completion: bytes with wstrb[i]=1 are committed on the RESP clock edge; other bytes are unchanged. rdata is unchanged.
- Read completion: rdata is loaded with the array word and becomes valid in the RESP cycle. rdata holds its value until the next read completion.
- Out-of-range (latched addr >= DEPTH): ready=1 and err=1. No array write; rdata is forced to 0.
- err is 0 whenever ready is 0.
- Back-to-back requests: if valid is still high in the cycle after RESP, IDLE accepts it as a new request. Minimum spacing is WAIT_STATES+2 cycles per transaction.
- The master must not change addr, wr_rd, wdata or wstrb while valid=1. The slave uses only the latched copies.
- Reset mid-transaction: the pending write is dropped and outputs return to their reset values.
- wstrb=0 on a write: ready pulses, no byte changes, err=0.

Optional Feature:
- Macro: MEM_WS_BANK_CLEAR_EN.
- Defined:
  - Adds input clr (1 bit) and output clr_busy (1 bit; reset 0).
  - A clr=1 sampled in IDLE takes priority over valid and enters CLEAR.
  - CLEAR writes zero to address 0..DEPTH-1, one word per cycle, with clr_busy=1. It then returns to IDLE.
  - During CLEAR: valid is ignored, ready=0, and clr pulses are ignored.
  - clr outside IDLE is ignored.
- Undefined: no clr/clr_busy ports, no CLEAR state, and the array is never cleared.

Decomposition:
- Package mem_pkg holds:
  - state encoding constants: IDLE=2'd0, WAIT=2'd1, RESP=2'd2, CLEAR=2'd3;
  - the wait-counter width constant (4);
  - the byte-lane width constant (8).
- Sub-module mem_ws_array: the storage. It has one synchronous write port with per-byte enables and one combinational read port, parametrised by WIDTH and DEPTH.
- The FSM, latches, range check and output registers stay in mem_ws_bank.

Test Plan:
- Single write then read, WAIT_STATES=1: write addr 8'h05, wdata 32'hA5A5_1234, wstrb 4'hF, then read 8'h05 -> ready exactly 2 cycles after acceptance each time, rdata=32'hA5A5_1234, err=0.
- Byte strobes: write 32'h1122_3344 (wstrb 4'hF) to addr 8'h10, then 32'hFFFF_FFFF with wstrb 4'b0101, then read -> rdata=32'h11FF_33FF.
- Out of range, DEPTH=200: write then read at addr 8'd200 -> ready=1, err=1, rdata=0. A subsequent read of addr 8'd199 returns its prior contents with err=0.
- Abort: read request with WAIT_STATES=3, drop valid after 1 cycle -> no ready pulse. A following full read of the same address completes normally in 4 cycles.
- Walking-ones/zeros sweep: addresses 1<<i and ~(1<<i) masked below DEPTH, random data 10..200; write all, then read all -> every read matches; WAIT_STATES=0 gives ready 1 cycle after acceptance.
- MEM_WS_BANK_CLEAR_EN defined: fill addrs 0..3 with nonzero data, pulse clr in IDLE -> clr_busy high for exactly DEPTH cycles, valid ignored meanwhile, then reads of 0..3 return 0. Assert res_n=0 mid-clear -> clr_busy=0 immediately.

Source files
------------

// File: rtl/mem_ws_bank_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_pkg
// Brief    : Shared state encoding and width constants for mem_ws_bank.
// Revision : 1.0
// ============================================================================
package mem_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t WAIT  = 2'd1;
    localparam state_t RESP  = 2'd2;
    localparam state_t CLEAR = 2'd3;

    localparam int c_CNT_W  = 4;
    localparam int c_BYTE_W = 8;

endpackage
`default_nettype wire

// File: rtl/mem_ws_bank_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_ws_array
// Brief    : Word storage with one byte-masked synchronous write port and one
//            combinational read port.
// Revision : 1.0
// ============================================================================
module mem_ws_array
    import mem_pkg::*;
#(
    parameter int  WIDTH      = 32,
    parameter int  DEPTH      = 200,
    parameter int  ADDR_WIDTH = $clog2(DEPTH),
    localparam int STRB_WIDTH = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [STRB_WIDTH-1:0] i_wstrb,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*c_BYTE_W +: c_BYTE_W] <= i_wdata[b*c_BYTE_W +: c_BYTE_W];
                end
            end
        end
    end

    // Addresses past the last word read as zero rather than indexing off the end.
    assign o_rdata = (32'(i_raddr) < 32'(DEPTH)) ? r_mem[i_raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/mem_ws_bank.sv
`default_nettype none
// ============================================================================
// Module   : mem_ws_bank
// Brief    : Single-port valid/ready memory slave with programmable wait
//            states, byte strobes, out-of-range error and request abort.
// Options  : MEM_WS_BANK_CLEAR_EN adds clr/clr_busy and a zero-fill sweep.
// Revision : 1.0
// ============================================================================
module mem_ws_bank
    import mem_pkg::*;
#(
    parameter int  WIDTH       = 32,
    parameter int  DEPTH       = 200,
    parameter int  ADDR_WIDTH  = $clog2(DEPTH),
    parameter int  WAIT_STATES = 1,
    localparam int STRB_WIDTH  = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
`ifdef MEM_WS_BANK_CLEAR_EN
    input  logic                  clr,
    output logic                  clr_busy,
`endif
    output logic [WIDTH-1:0]      rdata,
    output logic                  ready,
    output logic                  err
);

    localparam logic [c_CNT_W-1:0] c_WS_LOAD =
        (WAIT_STATES == 0) ? '0 : c_CNT_W'(WAIT_STATES - 1);
    localparam state_t c_AFTER_ACCEPT = (WAIT_STATES == 0) ? RESP : WAIT;

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wr;
    logic [WIDTH-1:0]      r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_oor;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]      r_rdata;

    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic                  w_req_wr;
    logic                  w_req_oor;
    logic                  w_accept;
    logic                  w_clr_req;
    logic                  w_clr_done;
    logic [ADDR_WIDTH-1:0] w_clr_addr;

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [WIDTH-1:0]      w_arr_wdata;
    logic [STRB_WIDTH-1:0] w_arr_wstrb;
    logic [WIDTH-1:0]      w_rd_word;

    // In IDLE the live bus is the request; afterwards only the latched copy counts.
    assign w_req_addr = (r_state == IDLE) ? addr  : r_addr;
    assign w_req_wr   = (r_state == IDLE) ? wr_rd : r_wr;
    assign w_req_oor  = 32'(w_req_addr) >= 32'(DEPTH);
    assign w_accept   = (r_state == IDLE) && valid && !w_clr_req;

`ifdef MEM_WS_BANK_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] c_CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] r_clr_addr;

    assign w_clr_req  = clr;
    assign w_clr_done = (r_clr_addr == c_CLR_LAST);
    assign w_clr_addr = r_clr_addr;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_clr_addr <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
        end else begin
            r_clr_addr <= '0;
        end
    end
`else
    assign w_clr_req  = 1'b0;
    assign w_clr_done = 1'b1;
    assign w_clr_addr = r_addr;
`endif

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_clr_req) begin
                    w_next = CLEAR;
                end else if (valid) begin
                    w_next = c_AFTER_ACCEPT;
                end
            end
            WAIT: begin
                if (!valid) begin
                    w_next = IDLE;
                end else if (r_cnt == '0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            CLEAR: begin
                if (w_clr_done) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ready       = 1'b0;
        err         = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_addr;
        w_arr_wdata = r_wdata;
        w_arr_wstrb = r_wstrb;
`ifdef MEM_WS_BANK_CLEAR_EN
        clr_busy    = 1'b0;
`endif
        case (r_state)
            RESP: begin
                ready = 1'b1;
                err   = r_oor;
                w_we  = r_wr && !r_oor;
            end
`ifdef MEM_WS_BANK_CLEAR_EN
            CLEAR: begin
                clr_busy    = 1'b1;
                w_we        = 1'b1;
                w_waddr     = w_clr_addr;
                w_arr_wdata = '0;
                w_arr_wstrb = '1;
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_oor   <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= addr;
                r_wr    <= wr_rd;
                r_wdata <= wdata;
                r_wstrb <= wstrb;
                r_oor   <= w_req_oor;
                r_cnt   <= c_WS_LOAD;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end

            // rdata is loaded on the edge entering RESP so it is valid with ready.
            if (w_next == RESP) begin
                if (w_req_oor) begin
                    r_rdata <= '0;
                end else if (!w_req_wr) begin
                    r_rdata <= w_rd_word;
                end
            end
        end
    end

    assign rdata = r_rdata;

    mem_ws_array #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_arr_wdata),
        .i_wstrb (w_arr_wstrb),
        .i_raddr (w_req_addr),
        .o_rdata (w_rd_word)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_ws_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ws_bank
// Brief    : Directed bench for mem_ws_bank; instances with 1, 3 and 0 wait
//            states. MEM_WS_BANK_CLEAR_EN enables the clear sequence.
// Revision : 1.0
// ============================================================================
module tb_mem_ws_bank;

    localparam int DEPTH = 200;

    logic              clk = 1'b0;
    logic              res_n;
    logic [2:0]        valid_v;
    logic              wr_rd;
    logic [7:0]        addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    wire  [2:0]        ready_v;
    wire  [2:0]        err_v;
    wire  [2:0][31:0]  rdata_v;
`ifdef MEM_WS_BANK_CLEAR_EN
    logic [2:0]        clr_v;
    wire  [2:0]        clr_busy_v;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        mem_ws_bank #(
            .WIDTH       (32),
            .DEPTH       (DEPTH),
            .ADDR_WIDTH  (8),
            .WAIT_STATES (WS)
        ) u_dut (
            .clk      (clk),
            .res_n    (res_n),
            .valid    (valid_v[g]),
            .wr_rd    (wr_rd),
            .addr     (addr),
            .wdata    (wdata),
            .wstrb    (wstrb),
`ifdef MEM_WS_BANK_CLEAR_EN
            .clr      (clr_v[g]),
            .clr_busy (clr_busy_v[g]),
`endif
            .rdata    (rdata_v[g]),
            .ready    (ready_v[g]),
            .err      (err_v[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request on instance d and wait (bounded) for its ready pulse.
    task automatic run_txn(input int d, input logic wr, input logic [7:0] a,
                           input logic [31:0] wd, input logic [3:0] ws,
                           output logic [31:0] rd, output logic e,
                           output int lat, output logic leak);
        logic done;
        wr_rd = wr; addr = a; wdata = wd; wstrb = ws;
        valid_v[d] = 1'b1;
        lat = 0; leak = 1'b0; done = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (!done) begin
                @(posedge clk); #1;
                if (err_v[d] && !ready_v[d]) leak = 1'b1;
                if (ready_v[d]) begin
                    lat  = n;
                    done = 1'b1;
                end
            end
        end
        rd = rdata_v[d];
        e  = err_v[d];
        valid_v[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    logic [31:0] model [256];
    logic [7:0]  sweep_q [$];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        logic        leak;
        int          lat;
        int          cnt;
        int          ecnt;

        vecs[0]  = '{1'b1, 8'h05, 32'hA5A5_1234, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 8'h05, 32'h0,         4'hF, 32'hA5A5_1234, 1'b0};
        vecs[2]  = '{1'b1, 8'h10, 32'h1122_3344, 4'hF, 32'hA5A5_1234, 1'b0};
        vecs[3]  = '{1'b1, 8'h10, 32'hFFFF_FFFF, 4'h5, 32'hA5A5_1234, 1'b0};
        vecs[4]  = '{1'b0, 8'h10, 32'h0,         4'hF, 32'h11FF_33FF, 1'b0};
        vecs[5]  = '{1'b1, 8'd199, 32'h0BAD_CAFE, 4'hF, 32'h11FF_33FF, 1'b0};
        vecs[6]  = '{1'b1, 8'd200, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 8'd200, 32'h0,         4'hF, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 8'd199, 32'h0,         4'hF, 32'h0BAD_CAFE, 1'b0};
        vecs[9]  = '{1'b1, 8'h20, 32'hCAFE_F00D, 4'hF, 32'h0BAD_CAFE, 1'b0};
        vecs[10] = '{1'b1, 8'h20, 32'h1234_5678, 4'h0, 32'h0BAD_CAFE, 1'b0};
        vecs[11] = '{1'b0, 8'h20, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0};
        vecs[12] = '{1'b1, 8'hFF, 32'h0,         4'hF, 32'h0000_0000, 1'b1};
        vecs[13] = '{1'b0, 8'h05, 32'h0,         4'hF, 32'hA5A5_1234, 1'b0};

        res_n = 1'b0; valid_v = '0; wr_rd = 1'b0; addr = '0; wdata = '0; wstrb = '0;
`ifdef MEM_WS_BANK_CLEAR_EN
        clr_v = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_ready[%0d]", d), 32'(ready_v[d]), 32'd0);
            check($sformatf("reset_err[%0d]", d),   32'(err_v[d]),   32'd0);
            check($sformatf("reset_rdata[%0d]", d), rdata_v[d],      32'd0);
        end
        res_n = 1'b1;
        @(posedge clk); #1;

        // Main table on the single-wait-state instance.
        for (int i = 0; i < 14; i++) begin
            run_txn(0, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].ws, rd, e, lat, leak);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err_without_ready", i), 32'(leak), 32'd0);
        end

        // Back-to-back: valid held high, pulses every WAIT_STATES+2 cycles.
        wr_rd = 1'b0; addr = 8'h05; wstrb = 4'hF;
        valid_v[0] = 1'b1;
        cnt = 0; ecnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ready_v[0]) cnt++;
            if (err_v[0]) ecnt++;
        end
        check("b2b_ready_pulses", 32'(cnt), 32'd3);
        check("b2b_err_count", 32'(ecnt), 32'd0);
        check("b2b_rdata", rdata_v[0], 32'hA5A5_1234);
        valid_v[0] = 1'b0;
        @(posedge clk); #1;

        // Reset during RESP drops the pending write.
        run_txn(0, 1'b1, 8'h28, 32'h2222_2222, 4'hF, rd, e, lat, leak);
        run_txn(0, 1'b0, 8'h05, 32'h0, 4'hF, rd, e, lat, leak);
        wr_rd = 1'b1; addr = 8'h28; wdata = 32'h1111_1111; wstrb = 4'hF;
        valid_v[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_in_resp", 32'(ready_v[0]), 32'd1);
        res_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready_v[0]), 32'd0);
        check("midrst_err", 32'(err_v[0]), 32'd0);
        check("midrst_rdata", rdata_v[0], 32'd0);
        valid_v[0] = 1'b0;
        @(posedge clk); #1;
        res_n = 1'b1;
        @(posedge clk); #1;
        run_txn(0, 1'b0, 8'h28, 32'h0, 4'hF, rd, e, lat, leak);
        check("midrst_write_dropped", rd, 32'h2222_2222);

        // Abort on the three-wait-state instance: early and at the last wait cycle.
        run_txn(1, 1'b1, 8'h30, 32'h5555_5555, 4'hF, rd, e, lat, leak);
        check("ws3_write_latency", 32'(lat), 32'd4);
        cnt = 0;
        wr_rd = 1'b1; addr = 8'h30; wdata = 32'h9999_9999; wstrb = 4'hF;
        valid_v[1] = 1'b1;
        @(posedge clk); #1;
        if (ready_v[1]) cnt++;
        valid_v[1] = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ready_v[1]) cnt++;
        end
        wdata = 32'h7777_7777;
        valid_v[1] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (ready_v[1]) cnt++;
        end
        valid_v[1] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (ready_v[1]) cnt++;
        end
        check("abort_no_ready", 32'(cnt), 32'd0);
        run_txn(1, 1'b0, 8'h30, 32'h0, 4'hF, rd, e, lat, leak);
        check("abort_read_latency", 32'(lat), 32'd4);
        check("abort_read_rdata", rd, 32'h5555_5555);
        check("abort_read_err", 32'(e), 32'd0);

        // Walking-ones/zeros sweep on the zero-wait-state instance.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a1;
            logic [7:0] a0;
            a1 = 8'(1 << i);
            a0 = ~a1;
            if (32'(a1) < DEPTH) sweep_q.push_back(a1);
            if (32'(a0) < DEPTH) sweep_q.push_back(a0);
        end
        foreach (sweep_q[k]) begin
            model[sweep_q[k]] = $urandom_range(200, 10);
            run_txn(2, 1'b1, sweep_q[k], model[sweep_q[k]], 4'hF, rd, e, lat, leak);
            check($sformatf("sweep_wr_latency_%0d", sweep_q[k]), 32'(lat), 32'd1);
        end
        foreach (sweep_q[k]) begin
            run_txn(2, 1'b0, sweep_q[k], 32'h0, 4'hF, rd, e, lat, leak);
            check($sformatf("sweep_rd_latency_%0d", sweep_q[k]), 32'(lat), 32'd1);
            check($sformatf("sweep_rd_data_%0d", sweep_q[k]), rd, model[sweep_q[k]]);
            check($sformatf("sweep_rd_err_%0d", sweep_q[k]), 32'(e), 32'd0);
        end

`ifdef MEM_WS_BANK_CLEAR_EN
        for (int k = 0; k < 4; k++) begin
            run_txn(0, 1'b1, 8'(k), 32'h0100_0000 + 32'(k) + 32'h1, 4'hF, rd, e, lat, leak);
        end
        clr_v[0] = 1'b1;
        @(posedge clk); #1;
        clr_v[0] = 1'b0;
        cnt  = clr_busy_v[0] ? 1 : 0;
        ecnt = ready_v[0] ? 1 : 0;
        wr_rd = 1'b1; addr = 8'd2; wdata = 32'hDEAD_0000; wstrb = 4'hF;
        valid_v[0] = 1'b1;
        for (int n = 0; n < DEPTH + 10; n++) begin
            if (n == 20) clr_v[0] = 1'b1;
            if (n == 21) clr_v[0] = 1'b0;
            if (n == 60) valid_v[0] = 1'b0;
            @(posedge clk); #1;
            if (clr_busy_v[0]) cnt++;
            if (ready_v[0]) ecnt++;
        end
        check("clear_busy_cycles", 32'(cnt), 32'(DEPTH));
        check("clear_ready_ignored", 32'(ecnt), 32'd0);
        for (int k = 0; k < 4; k++) begin
            run_txn(0, 1'b0, 8'(k), 32'h0, 4'hF, rd, e, lat, leak);
            check($sformatf("clear_read_%0d", k), rd, 32'd0);
        end
        clr_v[0] = 1'b1;
        @(posedge clk); #1;
        clr_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("clear_busy_before_reset", 32'(clr_busy_v[0]), 32'd1);
        res_n = 1'b0;
        #1;
        check("clear_busy_after_reset", 32'(clr_busy_v[0]), 32'd0);
        @(posedge clk); #1;
        res_n = 1'b1;
        @(posedge clk); #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
